// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT sequencing controller: default sizes,
// index width and FSM state encoding.
package fft_seq_pkg;

    localparam int NPTS_DEF = 128;
    localparam int IW_DEF   = 16;
    localparam int OW_DEF   = 20;
    localparam int TMO_DEF  = 4096;
    localparam int IDXW     = $clog2(NPTS_DEF);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_LOAD   = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_UNLOAD = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/fft_seq_cnt.sv
// Loadable up-counter with a terminal-count flag (count == TC).
module fft_seq_cnt #(
    parameter int W  = 7,
    parameter int TC = (1 << W) - 1
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = (count == W'(TC));

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer that feeds NPTS samples into a streaming FFT core and collects its results.
// Optional WAIT timeout with sticky err_o is enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_seq_ctrl
    import fft_seq_pkg::*;
#(
    parameter int NPTS = NPTS_DEF,
    parameter int IW   = IW_DEF,
    parameter int OW   = OW_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    go_i,
    input  logic                    abort_i,
    input  logic [3:0]              cfg_shift_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [IW-1:0]           in_re_i,
    input  logic [IW-1:0]           in_im_i,
    output logic                    fft_start_o,
    output logic                    fft_ed_o,
    output logic [IW-1:0]           fft_dr_o,
    output logic [IW-1:0]           fft_di_o,
    output logic [3:0]              fft_shift_o,
    input  logic                    fft_rdy_i,
    input  logic [OW-1:0]           fft_dor_i,
    input  logic [OW-1:0]           fft_doi_i,
    output logic                    out_valid_o,
    output logic [OW-1:0]           out_re_o,
    output logic [OW-1:0]           out_im_o,
    output logic [$clog2(NPTS)-1:0] out_idx_o
);

    localparam int XW = $clog2(NPTS);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      shift_q;
    logic            done_q;
    logic [XW-1:0]   idx_cnt;
    logic            idx_tc;
    logic            go_acc;
    logic            accept;
    logic            capture;
    logic            timeout;

    assign go_acc  = (state == ST_IDLE) && go_i;
    assign accept  = (state == ST_LOAD) && in_valid_i;
    assign capture = !abort_i && (((state == ST_WAIT) && fft_rdy_i) || (state == ST_UNLOAD));

    // One index counter serves both the input sample count and the output index.
    fft_seq_cnt #(.W(XW), .TC(NPTS - 1)) u_idx_cnt (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (go_acc || (accept && idx_tc)),
        .load_val ('0),
        .en       (accept || capture),
        .count    (idx_cnt),
        .tc       (idx_tc)
    );

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_tc;
    logic          err_q;

    fft_seq_cnt #(.W(TW), .TC(TMO - 1)) u_tmo_cnt (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (state != ST_WAIT),
        .load_val ('0),
        .en       (state == ST_WAIT),
        .count    (tmo_cnt),
        .tc       (tmo_tc)
    );

    assign timeout = (state == ST_WAIT) && tmo_tc && !fft_rdy_i && !abort_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            err_q <= 1'b0;
        else if (go_acc)
            err_q <= 1'b0;
        else if (timeout)
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (go_i) state_nxt = ST_START;
            ST_START:  state_nxt = ST_LOAD;
            ST_LOAD:   if (accept && idx_tc) state_nxt = ST_WAIT;
            ST_WAIT:   if (fft_rdy_i) state_nxt = ST_UNLOAD;
                       else if (timeout) state_nxt = ST_IDLE;
            ST_UNLOAD: if (idx_tc) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE && abort_i)
            state_nxt = ST_IDLE;
    end

    // done_o is registered so it trails the final out_valid_o by one cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            done_q      <= 1'b0;
            out_valid_o <= 1'b0;
            out_re_o    <= '0;
            out_im_o    <= '0;
            out_idx_o   <= '0;
        end else begin
            state       <= state_nxt;
            done_q      <= (state == ST_DONE) && !abort_i;
            out_valid_o <= capture;
            if (go_acc)
                shift_q <= cfg_shift_i;
            if (capture) begin
                out_re_o  <= fft_dor_i;
                out_im_o  <= fft_doi_i;
                out_idx_o <= idx_cnt;
            end
        end
    end

    assign done_o      = done_q;
    assign busy_o      = (state != ST_IDLE);
    assign in_ready_o  = (state == ST_LOAD);
    assign fft_start_o = (state == ST_START);
    assign fft_ed_o    = (state == ST_LOAD) ? in_valid_i
                                            : ((state == ST_WAIT) || (state == ST_UNLOAD));
    assign fft_dr_o    = (state == ST_LOAD) ? in_re_i : '0;
    assign fft_di_o    = (state == ST_LOAD) ? in_im_i : '0;
    assign fft_shift_o = shift_q;

endmodule
